// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the OpenMIPS pipeline control unit: reset/stop levels,
// exception codes and the exception-to-vector classification helper.
package pipeline_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic        STOP       = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    VEC_NONE = 2'd0,
    VEC_INT  = 2'd1,
    VEC_EXC  = 2'd2,
    VEC_EPC  = 2'd3
  } vec_sel_e;

  // Unknown nonzero codes are treated like any other synchronous exception.
  function automatic vec_sel_e decode_exc(input logic [31:0] code);
    vec_sel_e sel;
    case (code)
      ZERO_WORD: sel = VEC_NONE;
      EXC_INT:   sel = VEC_INT;
      EXC_SYS,
      EXC_INV,
      EXC_OV,
      EXC_TRAP:  sel = VEC_EXC;
      EXC_ERET:  sel = VEC_EPC;
      default:   sel = VEC_EXC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_mask_gen.sv
// Turns per-stage stall requests into a cumulative thermometer mask:
// every stage at or below the highest requester is held.
module stall_mask_gen
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] stallreq,
  output logic [STAGES-1:0] mask
);

  for (genvar i = 0; i < STAGES; i++) begin : g_therm
    assign mask[i] = (|stallreq[STAGES-1:i]) ? STOP : ~STOP;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall mask merge, exception redirect with multi-cycle
// flush, stall-cycle counter and sticky stall watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                 STAGES       = 6,
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  INT_VEC      = ADDR_W'(32'h0000_0020),
  parameter logic [ADDR_W-1:0]  EXC_VEC      = ADDR_W'(32'h0000_0040),
  parameter int                 FLUSH_CYCLES = 1,
  parameter int                 WDOG_LIMIT   = 255,
  parameter int                 CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [ADDR_W-1:0] cp0_epc_i,
  input  logic              clr_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              redirect_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              stall_timeout_o
);

  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM     = WD_W'(WDOG_LIMIT);
  localparam logic [FL_W-1:0] FL_RELOAD  = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST    = FL_W'(1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_r, state_s;
  logic [FL_W-1:0]   flush_left_r, flush_left_s;
  logic [ADDR_W-1:0] pc_q_r, pc_q_s;
  logic [ADDR_W-1:0] target_s;
  logic [STAGES-1:0] mask_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WD_W-1:0]   wd_r, wd_s;
  logic              timeout_r, timeout_s;
  logic              stalling_s;

  stall_mask_gen #(.STAGES(STAGES)) u_stall_mask_gen (
    .stallreq (stallreq_i),
    .mask     (mask_s)
  );

  // Redirect target for the exception currently presented by MEM.
  always_comb begin
    target_s = '0;
    case (decode_exc(excepttype_i))
      VEC_INT: target_s = INT_VEC;
      VEC_EXC: target_s = EXC_VEC;
      VEC_EPC: target_s = cp0_epc_i;
      default: target_s = '0;
    endcase
  end

  // Next state and pipeline control outputs; reset forces all outputs low
  // combinationally so nothing leaks through while rst is held.
  always_comb begin
    state_s      = state_r;
    flush_left_s = flush_left_r;
    pc_q_s       = pc_q_r;
    stall_o      = '0;
    flush_o      = 1'b0;
    redirect_o   = 1'b0;
    new_pc_o     = '0;
    if (rst == RST_ENABLE) begin
      state_s      = ST_RUN;
      flush_left_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (excepttype_i != ZERO_WORD) begin
            flush_o    = 1'b1;
            redirect_o = 1'b1;
            new_pc_o   = target_s;
            pc_q_s     = target_s;
            if (FLUSH_CYCLES > 1) begin
              state_s      = ST_FLUSH;
              flush_left_s = FL_RELOAD;
            end else begin
              state_s      = ST_RUN;
              flush_left_s = '0;
            end
          end else begin
            stall_o = mask_s;
          end
        end
        ST_FLUSH: begin
          flush_o  = 1'b1;
          new_pc_o = pc_q_r;
          if (flush_left_r <= FL_LAST) begin
            state_s      = ST_RUN;
            flush_left_s = '0;
          end else begin
            flush_left_s = flush_left_r - FL_LAST;
          end
        end
        default: begin
          state_s      = ST_RUN;
          flush_left_s = '0;
        end
      endcase
    end
  end

  assign stalling_s = |stall_o;

  // Stall-cycle counter and watchdog; clear wins over any increment.
  always_comb begin
    cnt_s     = cnt_r;
    wd_s      = wd_r;
    timeout_s = timeout_r;
    if (clr_i) begin
      cnt_s     = '0;
      wd_s      = '0;
      timeout_s = 1'b0;
    end else if (stalling_s) begin
      if (cnt_r != '1) begin
        cnt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_s = cnt_r;
      end
      if (wd_r < WD_LIM) begin
        wd_s = wd_r + WD_W'(1);
      end else begin
        wd_s = wd_r;
      end
      if (wd_s == WD_LIM) begin
        timeout_s = 1'b1;
      end else begin
        timeout_s = timeout_r;
      end
    end else begin
      wd_s = '0;
    end
  end

  // FSM, flush counter and captured redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_r      <= ST_RUN;
      flush_left_r <= '0;
      pc_q_r       <= '0;
    end else begin
      state_r      <= state_s;
      flush_left_r <= flush_left_s;
      pc_q_r       <= pc_q_s;
    end
  end

  // Performance counter and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_r     <= '0;
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      wd_r      <= wd_s;
      timeout_r <= timeout_s;
    end
  end

  assign stall_cnt_o     = cnt_r;
  assign stall_timeout_o = timeout_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a queue-free behavioural model,
// plus directed literal checks that pin the model's key behaviours.
module tb_pipeline_ctrl;

  localparam int STAGES = 6;
  localparam int ADDR_W = 32;
  localparam int FC     = 3;
  localparam int WDL    = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stallreq_i;
  logic [31:0]       excepttype_i;
  logic [ADDR_W-1:0] cp0_epc_i;
  logic              clr_i;
  logic [STAGES-1:0] stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              redirect_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              stall_timeout_o;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(
    .STAGES(STAGES), .ADDR_W(ADDR_W),
    .INT_VEC(32'h0000_0020), .EXC_VEC(32'h0000_0040),
    .FLUSH_CYCLES(FC), .WDOG_LIMIT(WDL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
    .cp0_epc_i(cp0_epc_i), .clr_i(clr_i), .stall_o(stall_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .redirect_o(redirect_o), .stall_cnt_o(stall_cnt_o),
    .stall_timeout_o(stall_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec_of(input logic [31:0] code, input logic [31:0] epc);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return epc;
    return 32'h40;
  endfunction

  // Behavioural model: remaining flush cycles, saved target, counters.
  int          m_rem = 0;
  logic [31:0] m_pc  = 32'h0;
  int          m_cnt = 0;
  int          m_wd  = 0;
  bit          m_to  = 1'b0;

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_redir;
    logic [31:0] e_pc;
    int          k;
    e_stall = '0; e_flush = 1'b0; e_redir = 1'b0; e_pc = '0;
    if (!rst) begin
      m_rem = 0; m_pc = '0; m_cnt = 0; m_wd = 0; m_to = 1'b0;
    end else if (m_rem > 0) begin
      e_flush = 1'b1; e_pc = m_pc; m_rem--;
    end else if (excepttype_i != 32'h0) begin
      e_flush = 1'b1; e_redir = 1'b1;
      e_pc = vec_of(excepttype_i, cp0_epc_i);
      m_pc = e_pc; m_rem = FC - 1;
    end else begin
      k = -1;
      for (int i = 0; i < STAGES; i++) if (stallreq_i[i]) k = i;
      e_stall = 6'((1 << (k + 1)) - 1);
    end
    check("m_stall",   64'(stall_o),         64'(e_stall));
    check("m_flush",   64'(flush_o),         64'(e_flush));
    check("m_redir",   64'(redirect_o),      64'(e_redir));
    check("m_new_pc",  64'(new_pc_o),        64'(e_pc));
    check("m_cnt",     64'(stall_cnt_o),     64'(m_cnt));
    check("m_timeout", 64'(stall_timeout_o), 64'(m_to));
    if (rst) begin
      if (e_stall != 0) begin
        if (m_cnt < 255) m_cnt++;
        if (m_wd < WDL) m_wd++;
        if (m_wd == WDL) m_to = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (clr_i) begin
        m_cnt = 0; m_wd = 0; m_to = 1'b0;
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] req, input logic [31:0] exc,
                      input logic [31:0] epc, input logic clr);
    @(posedge clk);
    #1;
    rst = r; stallreq_i = req; excepttype_i = exc; cp0_epc_i = epc; clr_i = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] codes [7];
    codes[0] = 32'h01; codes[1] = 32'h08; codes[2] = 32'h0a; codes[3] = 32'h0c;
    codes[4] = 32'h0d; codes[5] = 32'h0e; codes[6] = 32'h05;
    rst = 1'b0; stallreq_i = '0; excepttype_i = '0; cp0_epc_i = '0; clr_i = 1'b0;

    // Reset held with a pending stall request.
    step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
    step(1'b0, 6'b001000, 32'h0, 32'h0, 1'b0);
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_flush", 64'(flush_o), 64'h0);
    step(1'b1, 6'b001000, 32'h0, 32'h0, 1'b0);
    check("rel_stall", 64'(stall_o), 64'h0f);
    step(1'b1, 6'b000000, 32'h0, 32'h0, 1'b1);
    step(1'b1, 6'b001100, 32'h0, 32'h0, 1'b0);
    check("stall_ex_id", 64'(stall_o), 64'h0f);
    step(1'b1, 6'b000100, 32'h0, 32'h0, 1'b0);
    check("stall_id", 64'(stall_o), 64'h07);
    step(1'b1, 6'b000000, 32'h0, 32'h0, 1'b0);
    check("cnt_two", 64'(stall_cnt_o), 64'd2);

    // eret with three-cycle flush; interrupt during flush is ignored.
    step(1'b1, 6'b111111, 32'h0e, 32'h1234, 1'b0);
    check("eret_flush", 64'(flush_o), 64'h1);
    check("eret_redir", 64'(redirect_o), 64'h1);
    check("eret_pc", 64'(new_pc_o), 64'h1234);
    check("eret_stall", 64'(stall_o), 64'h0);
    step(1'b1, 6'b111111, 32'h01, 32'h0, 1'b0);
    check("fl2_redir", 64'(redirect_o), 64'h0);
    check("fl2_pc", 64'(new_pc_o), 64'h1234);
    step(1'b1, 6'b111111, 32'h01, 32'h0, 1'b0);
    check("fl3_flush", 64'(flush_o), 64'h1);
    check("fl3_pc", 64'(new_pc_o), 64'h1234);
    step(1'b1, 6'b000000, 32'h0, 32'h0, 1'b0);
    check("post_flush", 64'(flush_o), 64'h0);
    check("post_pc", 64'(new_pc_o), 64'h0);

    // Vector decode, back-to-back exception right after a flush.
    step(1'b1, 6'b0, 32'h01, 32'h0, 1'b0);
    check("int_pc", 64'(new_pc_o), 64'h20);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 6'b0, 32'h0c, 32'h0, 1'b0);
    check("ov_pc", 64'(new_pc_o), 64'h40);
    check("ov_redir", 64'(redirect_o), 64'h1);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 6'b0, 32'h05, 32'h0, 1'b0);
    check("unk_pc", 64'(new_pc_o), 64'h40);
    check("unk_flush", 64'(flush_o), 64'h1);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);

    // Watchdog at limit 4, sticky until clear.
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 6'b000001, 32'h0, 32'h0, 1'b0);
    check("wd_before", 64'(stall_timeout_o), 64'h0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    check("wd_set", 64'(stall_timeout_o), 64'h1);
    check("wd_cnt", 64'(stall_cnt_o), 64'd4);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    check("wd_sticky", 64'(stall_timeout_o), 64'h1);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    check("clr_to", 64'(stall_timeout_o), 64'h0);
    check("clr_cnt", 64'(stall_cnt_o), 64'h0);

    // Reset in flush cycle 2 aborts the flush.
    step(1'b1, 6'b0, 32'h08, 32'h0, 1'b0);
    check("sys_flush", 64'(flush_o), 64'h1);
    step(1'b0, 6'b0, 32'h0, 32'h0, 1'b0);
    check("abort_flush", 64'(flush_o), 64'h0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    check("after_rst_flush", 64'(flush_o), 64'h0);
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b0);
    check("after_rst_flush2", 64'(flush_o), 64'h0);

    // Counter saturation.
    step(1'b1, 6'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 300; i++)
      step(1'b1, 6'($urandom_range(1, 63)), 32'h0, 32'h0, 1'b0);
    check("cnt_sat", 64'(stall_cnt_o), 64'd255);
    check("sat_to", 64'(stall_timeout_o), 64'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] exc;
      exc = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      step(($urandom_range(0, 199) != 0), 6'($urandom), exc, $urandom,
           ($urandom_range(0, 31) == 0));
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
